// File: rtl/traffic_pkg.sv
// Shared aspect/fault encodings and default timing for the traffic light controller
// and its downstream lamp conflict monitor.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED    = 3'd0,
    YELLOW = 3'd1,
    GREEN  = 3'd2,
    DARK   = 3'd3,
    MULTI  = 3'd4
  } aspect_t;

  typedef enum logic [2:0] {
    FC_NONE  = 3'd0,
    FC_MULTI = 3'd1,
    FC_DARK  = 3'd2,
    FC_SEQ   = 3'd3,
    FC_DWELL = 3'd4
  } fault_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_t;

  localparam int unsigned T_CNT_W      = 8;
  localparam int unsigned T_MIN_RED    = 20;
  localparam int unsigned T_MIN_YELLOW = 2;
  localparam int unsigned T_MIN_GREEN  = 15;
  localparam int unsigned T_DARK_MAX   = 3;
  localparam int unsigned T_FLASH_HALF = 5;

  function automatic aspect_t decode_aspect(input logic r, input logic y, input logic g);
    aspect_t a;
    case ({r, y, g})
      3'b100:  a = RED;
      3'b010:  a = YELLOW;
      3'b001:  a = GREEN;
      3'b000:  a = DARK;
      default: a = MULTI;
    endcase
    return a;
  endfunction

  // The only legal aspect changes: RED->GREEN->YELLOW->RED.
  function automatic logic legal_step(input aspect_t from, input aspect_t to);
    return ((from == RED)    && (to == GREEN))  ||
           ((from == GREEN)  && (to == YELLOW)) ||
           ((from == YELLOW) && (to == RED));
  endfunction

endpackage

// File: rtl/lamp_flasher.sv
// Square-wave generator for the fault lamp: lit for half_period cycles, dark for
// half_period cycles, restarting lit on the first cycle that en is seen high.
module lamp_flasher #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] half_period,
  output logic             blink
);

  logic             en_q;
  logic [CNT_W-1:0] cnt_q;
  logic             blink_q;
  logic             wrap;

  assign wrap  = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, half_period};
  assign blink = blink_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      en_q <= en;
      // Advance only once en has been high for a full cycle; otherwise hold at the lit phase start.
      if (en && en_q) begin
        if (wrap) begin
          cnt_q   <= '0;
          blink_q <= ~blink_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q   <= '0;
        blink_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Lamp conflict monitor: registers the controller's R/Y/G aspect onto the lamps and
// forces flashing red with a latched fault code on any multi-lamp, dark, sequence or dwell violation.
module lamp_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W      = T_CNT_W,
  parameter int unsigned MIN_RED    = T_MIN_RED,
  parameter int unsigned MIN_GREEN  = T_MIN_GREEN,
  parameter int unsigned MIN_YELLOW = T_MIN_YELLOW,
  parameter int unsigned DARK_MAX   = T_DARK_MAX,
  parameter int unsigned FLASH_HALF = T_FLASH_HALF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r_in,
  input  logic       y_in,
  input  logic       g_in,
  input  logic       clr_fault,
  output logic       r_out,
  output logic       y_out,
  output logic       g_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] MIN_RED_C    = CNT_W'(MIN_RED);
  localparam logic [CNT_W-1:0] MIN_GREEN_C  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_YELLOW_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] DARK_MAX_C   = CNT_W'(DARK_MAX);
  localparam logic [CNT_W-1:0] FLASH_HALF_C = CNT_W'(FLASH_HALF);

  aspect_t          asp;
  mon_state_t       state_q, state_d;
  aspect_t          last_q, last_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] dark_q, dark_d;
  fault_t           code_q, code_d;
  logic             r_q, y_q, g_q;
  logic             r_d, y_d, g_d;

  logic [CNT_W-1:0] dwell_inc, dark_inc, min_dwell;
  logic             v_multi, v_dark, v_seq, v_dwell;
  logic             blink;

  assign asp = decode_aspect(r_in, y_in, g_in);

  // Saturating increments so a very long hold can never wrap into a false short dwell.
  assign dwell_inc = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_W'(1);
  assign dark_inc  = (dark_q  == CNT_MAX) ? dark_q  : dark_q  + CNT_W'(1);

  always_comb begin
    case (last_q)
      GREEN:   min_dwell = MIN_GREEN_C;
      YELLOW:  min_dwell = MIN_YELLOW_C;
      default: min_dwell = MIN_RED_C;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    dark_d  = dark_q;
    code_d  = code_q;
    v_multi = 1'b0;
    v_dark  = 1'b0;
    v_seq   = 1'b0;
    v_dwell = 1'b0;

    case (state_q)
      ST_INIT: begin
        last_d  = RED;
        dwell_d = '0;
        dark_d  = '0;
        if (asp == RED) begin
          state_d = ST_MONITOR;
          dwell_d = CNT_W'(1);
        end
      end

      ST_MONITOR: begin
        case (asp)
          MULTI: v_multi = 1'b1;
          DARK: begin
            dark_d = dark_inc;
            v_dark = dark_inc > DARK_MAX_C;
          end
          default: begin
            dark_d = '0;
            if (asp == last_q) begin
              dwell_d = dwell_inc;
            end else if (!legal_step(last_q, asp)) begin
              v_seq = 1'b1;
            end else if (dwell_q < min_dwell) begin
              v_dwell = 1'b1;
            end else begin
              dwell_d = CNT_W'(1);
              last_d  = asp;
            end
          end
        endcase

        if (v_multi) begin
          state_d = ST_FAULT;
          code_d  = FC_MULTI;
        end else if (v_seq) begin
          state_d = ST_FAULT;
          code_d  = FC_SEQ;
        end else if (v_dwell) begin
          state_d = ST_FAULT;
          code_d  = FC_DWELL;
        end else if (v_dark) begin
          state_d = ST_FAULT;
          code_d  = FC_DARK;
        end
      end

      ST_FAULT: begin
        if (clr_fault && (asp == RED)) begin
          state_d = ST_INIT;
          code_d  = FC_NONE;
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Lamps follow the inputs only when this cycle stays clean; otherwise solid red (flash overrides in FAULT).
    if (state_d == ST_MONITOR) begin
      {r_d, y_d, g_d} = {r_in, y_in, g_in};
    end else begin
      {r_d, y_d, g_d} = 3'b100;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      last_q  <= RED;
      dwell_q <= '0;
      dark_q  <= '0;
      code_q  <= FC_NONE;
      r_q     <= 1'b1;
      y_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      dark_q  <= dark_d;
      code_q  <= code_d;
      r_q     <= r_d;
      y_q     <= y_d;
      g_q     <= g_d;
    end
  end

  lamp_flasher #(
    .CNT_W(CNT_W)
  ) u_flasher (
    .clk        (clk),
    .reset      (reset),
    .en         (state_d == ST_FAULT),
    .half_period(FLASH_HALF_C),
    .blink      (blink)
  );

  assign r_out      = (state_q == ST_FAULT) ? blink : r_q;
  assign y_out      = y_q;
  assign g_out      = g_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Bench for lamp_conflict_monitor: directed scenarios plus randomized aspect sequences,
// all outputs compared every cycle against a history-based reference model.
module tb_lamp_conflict_monitor;

  localparam int A_RED = 0, A_YEL = 1, A_GRN = 2, A_DARK = 3, A_MULTI = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r_in = 1'b1, y_in = 1'b0, g_in = 1'b0, clr_fault = 1'b0;
  logic       r_out, y_out, g_out, fault;
  logic [2:0] fault_code;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 INIT, 1 MONITOR, 2 FAULT; history of lit aspects since monitoring began.
  int   m_mode = 0;
  int   m_hist[$];
  int   m_dark = 0;
  int   m_fk   = 0;
  int   m_code = 0;
  logic e_r = 1'b1, e_y = 1'b0, e_g = 1'b0;
  int   min_dw [3] = '{20, 2, 15};
  int   nxt    [3] = '{A_GRN, A_RED, A_YEL};

  lamp_conflict_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .r_in      (r_in),
    .y_in      (y_in),
    .g_in      (g_in),
    .clr_fault (clr_fault),
    .r_out     (r_out),
    .y_out     (y_out),
    .g_out     (g_out),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic int aspect_of(input logic r, input logic y, input logic g);
    int n;
    n = int'(r) + int'(y) + int'(g);
    if (n == 0) return A_DARK;
    if (n > 1) return A_MULTI;
    return r ? A_RED : (y ? A_YEL : A_GRN);
  endfunction

  // Length of the current run of aspect a at the end of the history, capped like an 8-bit counter.
  function automatic int trailing(input int a);
    int n;
    n = 0;
    for (int i = m_hist.size() - 1; i >= 0; i--) begin
      if (m_hist[i] != a) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic y, input logic g,
                            input logic clr, input logic rst);
    int a;
    int v;
    int last;
    a = aspect_of(r, y, g);
    v = 0;
    if (rst) begin
      m_mode = 0;
      m_code = 0;
      m_dark = 0;
      m_hist.delete();
    end else begin
      case (m_mode)
        0: begin
          if (a == A_RED) begin
            m_mode = 1;
            m_dark = 0;
            m_hist.delete();
            m_hist.push_back(A_RED);
          end
        end
        1: begin
          if (a == A_MULTI) begin
            v = 1;
          end else if (a == A_DARK) begin
            m_dark++;
            if (m_dark > 3) v = 2;
          end else begin
            last = m_hist[$];
            m_dark = 0;
            if (a == last) m_hist.push_back(a);
            else if (nxt[last] != a) v = 3;
            else if (trailing(last) < min_dw[last]) v = 4;
            else m_hist.push_back(a);
          end
          if (m_hist.size() > 300) void'(m_hist.pop_front());
          if (v != 0) begin
            m_mode = 2;
            m_code = v;
            m_fk   = 0;
          end
        end
        default: begin
          m_fk++;
          if (clr && (a == A_RED)) begin
            m_mode = 0;
            m_code = 0;
          end
        end
      endcase
    end
    if (m_mode == 1) {e_r, e_y, e_g} = {r, y, g};
    else if (m_mode == 2) {e_r, e_y, e_g} = {((m_fk / 5) % 2 == 0), 1'b0, 1'b0};
    else {e_r, e_y, e_g} = 3'b100;
  endtask

  task automatic cycle(input logic r, input logic y, input logic g,
                       input logic clr, input logic rst);
    @(negedge clk);
    r_in = r; y_in = y; g_in = g; clr_fault = clr; reset = rst;
    @(posedge clk);
    model_step(r, y, g, clr, rst);
    #1;
    check_eq("r_out", r_out, e_r);
    check_eq("y_out", y_out, e_y);
    check_eq("g_out", g_out, e_g);
    check_eq("fault", fault, (m_mode == 2));
    check_eq("fault_code", fault_code, m_code);
  endtask

  task automatic hold(input logic r, input logic y, input logic g, input int n);
    repeat (n) cycle(r, y, g, 1'b0, 1'b0);
  endtask

  initial begin
    int          cur;
    int          p;
    int          nx;
    int          len;
    logic [2:0]  pat;

    $display("scenario 1: reset, legal R21/G16/Y3 loop x3");
    repeat (3) cycle(1, 0, 0, 0, 1);
    check_eq("reset_code", fault_code, 0);
    check_eq("reset_r", r_out, 1);
    repeat (3) begin
      hold(1, 0, 0, 21); hold(0, 0, 1, 16); hold(0, 1, 0, 3);
    end

    $display("scenario 2: multi-lamp in green, flash, clear handling");
    hold(1, 0, 0, 21); hold(0, 0, 1, 5);
    cycle(1, 0, 1, 0, 0);
    check_eq("s2_code", fault_code, 1);
    check_eq("s2_g", g_out, 0);
    hold(0, 0, 1, 12);
    cycle(0, 0, 1, 1, 0);
    check_eq("s5_clr_ignored", fault, 1);
    cycle(1, 0, 0, 1, 0);
    check_eq("s5_cleared", fault_code, 0);
    cycle(1, 0, 0, 0, 0);

    $display("scenario 3: short red dwell, then red->yellow");
    hold(1, 0, 0, 9); cycle(0, 0, 1, 0, 0);
    check_eq("s3_dwell", fault_code, 4);
    hold(1, 0, 0, 3); cycle(1, 0, 0, 1, 0);
    hold(1, 0, 0, 25); cycle(0, 1, 0, 0, 0);
    check_eq("s3_seq", fault_code, 3);
    cycle(1, 0, 0, 1, 0);

    $display("scenario 4: dark gaps of 3 and 4 in green");
    hold(1, 0, 0, 21); hold(0, 0, 1, 5); hold(0, 0, 0, 3); hold(0, 0, 1, 10);
    hold(0, 1, 0, 3); hold(1, 0, 0, 21); hold(0, 0, 1, 5); hold(0, 0, 0, 4);
    check_eq("s4_dark", fault_code, 2);

    $display("scenario 6: reset mid-fault");
    hold(0, 0, 1, 7);
    cycle(0, 0, 1, 0, 1);
    check_eq("s6_fault", fault, 0);
    check_eq("s6_r", r_out, 1);
    hold(1, 0, 0, 2);

    $display("scenario 7: red held 300 cycles then legal change");
    hold(1, 0, 0, 298); hold(0, 0, 1, 16); hold(0, 1, 0, 3); hold(1, 0, 0, 20);
    check_eq("s7_nofault", fault, 0);

    $display("scenario 8: randomized aspect sequences");
    cur = A_RED;
    for (int s = 0; s < 300; s++) begin
      p = $urandom_range(0, 99);
      if (m_mode == 2) begin
        len = $urandom_range(1, 12);
        repeat (len) begin
          pat = 3'($urandom_range(0, 7));
          cycle(pat[2], pat[1], pat[0], 1'($urandom_range(0, 1)), 0);
        end
        cycle(1, 0, 0, 1, 0);
        cur = A_RED;
      end else if (p < 5) begin
        pat = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b011;
        cycle(pat[2], pat[1], pat[0], 0, 0);
      end else if (p < 15) begin
        hold(0, 0, 0, $urandom_range(1, 5));
      end else if (p < 18) begin
        cycle(1, 0, 0, 0, 1);
        cur = A_RED;
      end else begin
        nx  = (p < 90) ? nxt[cur] : $urandom_range(0, 2);
        len = $urandom_range(min_dw[nx] - 2, min_dw[nx] + 3);
        if (len < 1) len = 1;
        hold(nx == A_RED, nx == A_YEL, nx == A_GRN, len);
        cur = nx;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
